// File: rtl/ft_pkg.sv
// Shared constants for the FT601 transmit path: packet header fields and
// scheduler state encoding.
package ft_pkg;

  localparam logic [7:0] HDR_SYNC  = 8'hA5;
  localparam logic [3:0] TYPE_SAMP = 4'h1;
  localparam logic [3:0] TYPE_EVT  = 4'h2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_SAMP = 2'd2;
  localparam logic [1:0] ST_EVT  = 2'd3;

  localparam logic GRANT_SAMP = 1'b0;
  localparam logic GRANT_EVT  = 1'b1;

  // Header word: sync byte, packet type, sequence number, payload length.
  function automatic logic [31:0] make_hdr(input logic [3:0] typ,
                                           input logic [3:0] seq,
                                           input logic [15:0] len);
    return {HDR_SYNC, typ, seq, len};
  endfunction

endpackage

// File: rtl/ft_tx_sched_if.sv
// Scheduler bus bundle: sample FIFO read side, event channel and the
// word stream towards the FT601 bus FSM.
interface ft_tx_sched_if #(
  parameter int unsigned DATA_LEN = 32,
  parameter int unsigned ADDR_LEN = 10
);
  logic [ADDR_LEN:0]   s_level;
  logic                s_empty;
  logic [DATA_LEN-1:0] s_data;
  logic                s_pop;
  logic                ev_valid;
  logic [DATA_LEN-1:0] ev_data;
  logic                ev_ready;
  logic                m_valid;
  logic [DATA_LEN-1:0] m_data;
  logic                m_last;
  logic                m_ready;

  modport master (
    input  s_level, s_empty, s_data, ev_valid, ev_data, m_ready,
    output s_pop, ev_ready, m_valid, m_data, m_last
  );

  modport slave (
    output s_level, s_empty, s_data, ev_valid, ev_data, m_ready,
    input  s_pop, ev_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/ft_tx_sched.sv
// FT601 transmit scheduler: round-robin between sample FIFO bursts and single
// event words, each wrapped in a packet with a header word.
module ft_tx_sched
  import ft_pkg::*;
#(
  parameter int unsigned DATA_LEN  = 32,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned ADDR_LEN  = 10
) (
  input  logic             clk,
  input  logic             rst,
  ft_tx_sched_if.master    bus,
  output logic             busy
);

  localparam int unsigned LVL_W = ADDR_LEN + 1;
  localparam int unsigned LEN_W = 16;
  localparam int unsigned CMP_W = (LVL_W > LEN_W) ? LVL_W : LEN_W;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [3:0]       typ;
  logic [3:0]       seq;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] cnt;
  logic             last_grant;

  logic             samp_req;
  logic             evt_req;
  logic             grant_samp;
  logic             grant_evt;
  logic             samp_xfer;
  logic             evt_xfer;
  logic             last_xfer;
  logic [CMP_W-1:0] level_ext;
  logic [CMP_W-1:0] burst_ext;
  logic [LEN_W-1:0] samp_len;

  assign samp_req  = (bus.s_level != '0);
  assign evt_req   = bus.ev_valid;
  assign level_ext = CMP_W'(bus.s_level);
  assign burst_ext = CMP_W'(BURST_LEN);
  assign samp_len  = (level_ext < burst_ext) ? LEN_W'(level_ext) : LEN_W'(burst_ext);

  assign samp_xfer = (state == ST_SAMP) && !bus.s_empty && bus.m_ready;
  assign evt_xfer  = (state == ST_EVT) && bus.m_ready;
  assign last_xfer = (samp_xfer && (cnt == LEN_W'(1))) || evt_xfer;

  assign busy = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, arbitration and output decode.
  always_comb begin
    state_nxt    = state;
    grant_samp   = 1'b0;
    grant_evt    = 1'b0;
    bus.m_valid  = 1'b0;
    bus.m_data   = '0;
    bus.m_last   = 1'b0;
    bus.s_pop    = 1'b0;
    bus.ev_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        // On a tie the requester not served last wins.
        if (evt_req && (!samp_req || (last_grant == GRANT_SAMP))) begin
          grant_evt = 1'b1;
          state_nxt = ST_HDR;
        end else if (samp_req) begin
          grant_samp = 1'b1;
          state_nxt  = ST_HDR;
        end
      end
      ST_HDR: begin
        bus.m_valid = 1'b1;
        bus.m_data  = DATA_LEN'(make_hdr(typ, seq, len));
        if (bus.m_ready) state_nxt = (typ == TYPE_SAMP) ? ST_SAMP : ST_EVT;
      end
      ST_SAMP: begin
        bus.m_valid = !bus.s_empty;
        bus.m_data  = bus.s_data;
        bus.m_last  = (cnt == LEN_W'(1));
        bus.s_pop   = samp_xfer;
        if (samp_xfer && (cnt == LEN_W'(1))) state_nxt = ST_IDLE;
      end
      ST_EVT: begin
        bus.m_valid  = 1'b1;
        bus.m_data   = bus.ev_data;
        bus.m_last   = 1'b1;
        bus.ev_ready = evt_xfer;
        if (evt_xfer) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Packet context latched at grant; word counter and sequence number.
  always_ff @(posedge clk) begin
    if (rst) begin
      typ        <= 4'h0;
      len        <= '0;
      cnt        <= '0;
      seq        <= 4'h0;
      last_grant <= GRANT_SAMP;
    end else begin
      if (grant_evt) begin
        typ        <= TYPE_EVT;
        len        <= LEN_W'(1);
        cnt        <= LEN_W'(1);
        last_grant <= GRANT_EVT;
      end else if (grant_samp) begin
        typ        <= TYPE_SAMP;
        len        <= samp_len;
        cnt        <= samp_len;
        last_grant <= GRANT_SAMP;
      end else if (samp_xfer) begin
        cnt <= cnt - LEN_W'(1);
      end
      if (last_xfer) seq <= seq + 4'h1;
    end
  end

endmodule

// File: tb/tb_ft_tx_sched.sv
// Directed bench for ft_tx_sched with a small FIFO model on the sample side.
module tb_ft_tx_sched;

  logic clk = 1'b0;
  logic rst;
  logic busy;

  always #5 clk = ~clk;

  ft_tx_sched_if #(.DATA_LEN(32), .ADDR_LEN(10)) bus ();

  ft_tx_sched #(.DATA_LEN(32), .BURST_LEN(4), .ADDR_LEN(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  // Sample FIFO model: first-word-fall-through head, popped by s_pop.
  logic [31:0] mem [0:255];
  logic [7:0]  wr;
  logic [7:0]  rd;
  logic        force_empty;
  logic        fifo_flush;

  assign bus.s_level = 11'(wr - rd);
  assign bus.s_empty = (wr == rd) || force_empty;
  assign bus.s_data  = mem[rd];

  always @(posedge clk) begin
    if (fifo_flush)     rd <= wr;
    else if (bus.s_pop) rd <= rd + 8'd1;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr] = d;
    wr = wr + 8'd1;
  endtask

  task automatic chk_idle(input string tag);
    chk_b({tag, "_busy"},     busy,         1'b0);
    chk_b({tag, "_valid"},    bus.m_valid,  1'b0);
    chk_b({tag, "_last"},     bus.m_last,   1'b0);
    chk_b({tag, "_pop"},      bus.s_pop,    1'b0);
    chk_b({tag, "_ev_ready"}, bus.ev_ready, 1'b0);
  endtask

  task automatic chk_hdr(input string tag, input logic [31:0] hdr);
    chk_b({tag, "_hdr_valid"}, bus.m_valid, 1'b1);
    chk_w({tag, "_hdr_data"},  bus.m_data,  hdr);
    chk_b({tag, "_hdr_last"},  bus.m_last,  1'b0);
    chk_b({tag, "_hdr_pop"},   bus.s_pop,   1'b0);
    chk_b({tag, "_hdr_busy"},  busy,        1'b1);
  endtask

  task automatic chk_samp(input string tag, input logic [31:0] w, input logic last);
    chk_b({tag, "_s_valid"}, bus.m_valid, 1'b1);
    chk_w({tag, "_s_data"},  bus.m_data,  w);
    chk_b({tag, "_s_last"},  bus.m_last,  last);
    chk_b({tag, "_s_pop"},   bus.s_pop,   1'b1);
  endtask

  task automatic chk_evt(input string tag, input logic [31:0] w);
    chk_b({tag, "_e_valid"}, bus.m_valid,  1'b1);
    chk_w({tag, "_e_data"},  bus.m_data,   w);
    chk_b({tag, "_e_last"},  bus.m_last,   1'b1);
    chk_b({tag, "_e_ready"}, bus.ev_ready, 1'b1);
    chk_b({tag, "_e_pop"},   bus.s_pop,    1'b0);
  endtask

  // Entered with the IDLE cycle visible and a sample request pending.
  task automatic samp_pkt(input string tag, input logic [31:0] hdr,
                          input logic [31:0] base, input int unsigned step,
                          input int unsigned n);
    tick();
    chk_hdr(tag, hdr);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      chk_samp(tag, base + 32'(i * step), (i == n - 1));
    end
    tick();
    chk_idle({tag, "_end"});
  endtask

  initial begin
    rst           = 1'b1;
    fifo_flush    = 1'b1;
    force_empty   = 1'b0;
    wr            = 8'd0;
    bus.m_ready   = 1'b1;
    bus.ev_valid  = 1'b0;
    bus.ev_data   = 32'h0;
    repeat (3) tick();
    chk_idle("reset");
    fifo_flush = 1'b0;

    // Tie out of reset: event first, then samples.
    push(32'h11); push(32'h22); push(32'h33);
    bus.ev_valid = 1'b1;
    bus.ev_data  = 32'hE0E0_0001;
    rst = 1'b0;
    settle();
    chk_idle("tie_first_idle");
    tick();
    chk_hdr("tie_evt", 32'hA520_0001);
    tick();
    chk_evt("tie_evt", 32'hE0E0_0001);
    tick();
    bus.ev_data = 32'hE0E0_0002;
    settle();
    chk_idle("tie_gap");
    // Both pending again: samples win since the event was served last.
    samp_pkt("samp3", 32'hA511_0003, 32'h11, 32'h11, 3);
    tick();
    chk_hdr("tie2_evt", 32'hA522_0001);
    tick();
    chk_evt("tie2_evt", 32'hE0E0_0002);
    tick();
    bus.ev_valid = 1'b0;
    settle();
    chk_idle("tie2_end");

    // Burst cap of 4 with 10 words queued.
    for (int i = 0; i < 10; i++) push(32'h100 + 32'(i));
    samp_pkt("burst_a", 32'hA513_0004, 32'h100, 1, 4);
    samp_pkt("burst_b", 32'hA514_0004, 32'h104, 1, 4);
    samp_pkt("burst_c", 32'hA515_0002, 32'h108, 1, 2);
    chk_w("burst_drained", 32'(bus.s_level), 32'd0);

    // Backpressure in HDR and mid-SAMP.
    for (int i = 0; i < 4; i++) push(32'h200 + 32'(i));
    tick();
    chk_hdr("bp", 32'hA516_0004);
    bus.m_ready = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk_hdr("bp_hold", 32'hA516_0004);
      tick();
    end
    bus.m_ready = 1'b1;
    settle();
    chk_hdr("bp_rel", 32'hA516_0004);
    tick();
    chk_samp("bp_w0", 32'h200, 1'b0);
    tick();
    chk_samp("bp_w1", 32'h201, 1'b0);
    bus.m_ready = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk_w("bp_s_data", bus.m_data,  32'h201);
      chk_b("bp_s_last", bus.m_last,  1'b0);
      chk_b("bp_s_pop",  bus.s_pop,   1'b0);
      tick();
    end
    bus.m_ready = 1'b1;
    settle();
    chk_samp("bp_w1_rel", 32'h201, 1'b0);
    tick();
    chk_samp("bp_w2", 32'h202, 1'b0);
    tick();
    chk_samp("bp_w3", 32'h203, 1'b1);
    tick();
    chk_idle("bp_end");

    // Stall: s_empty for 3 cycles in the middle of SAMP.
    push(32'h300); push(32'h301); push(32'h302);
    tick();
    chk_hdr("stall", 32'hA517_0003);
    tick();
    chk_samp("stall_w0", 32'h300, 1'b0);
    tick();
    chk_samp("stall_w1", 32'h301, 1'b0);
    force_empty = 1'b1;
    settle();
    for (int k = 0; k < 3; k++) begin
      chk_b("stall_valid", bus.m_valid, 1'b0);
      chk_b("stall_pop",   bus.s_pop,   1'b0);
      chk_b("stall_busy",  busy,        1'b1);
      tick();
    end
    force_empty = 1'b0;
    settle();
    chk_samp("stall_w1_rel", 32'h301, 1'b0);
    tick();
    chk_samp("stall_w2", 32'h302, 1'b1);
    tick();
    chk_idle("stall_end");

    // Eight events take seq 8..15, then it wraps to 0.
    for (int i = 0; i < 8; i++) begin
      bus.ev_valid = 1'b1;
      bus.ev_data  = 32'hE100_0000 + 32'(i);
      tick();
      chk_hdr("wrap_evt", {8'hA5, 4'h2, 4'(8 + i), 16'd1});
      tick();
      chk_evt("wrap_evt", 32'hE100_0000 + 32'(i));
      tick();
      bus.ev_valid = 1'b0;
      settle();
      chk_idle("wrap_evt_end");
    end
    push(32'h400);
    samp_pkt("wrap_samp", 32'hA510_0001, 32'h400, 1, 1);

    // Reset in SAMP with two words still to go.
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(i));
    tick();
    chk_hdr("rstmid", 32'hA511_0004);
    tick();
    chk_samp("rstmid_w0", 32'h500, 1'b0);
    tick();
    chk_samp("rstmid_w1", 32'h501, 1'b0);
    tick();
    chk_samp("rstmid_w2", 32'h502, 1'b0);
    rst        = 1'b1;
    fifo_flush = 1'b1;
    tick();
    chk_idle("rstmid_after");
    rst        = 1'b0;
    fifo_flush = 1'b0;
    settle();
    chk_w("rstmid_level", 32'(bus.s_level), 32'd0);
    push(32'h600);
    samp_pkt("post_rst", 32'hA510_0001, 32'h600, 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
